// File: rtl/xor_sweep_pkg.sv
// Shared types and helpers for the XOR-with-invert sweep checker.
package xor_sweep_pkg;

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      WAIT,
      CHECK,
      DONE
   } state_t;

   // Expected cell output for a vector and invert level. The vector is
   // passed zero-extended, and the extra zero bits do not alter the parity.
   function automatic logic exp_parity(input logic [31:0] vec, input logic inv);
      return (^vec) ^ inv;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // Count increments until every bit is set, then sticks there.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {WIDTH{1'b1}})) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/xor_sweep_checker.sv
// Sweeps every input vector through an XOR-with-invert cell, once with the
// invert control low and once high, and scores each response.
module xor_sweep_checker
   import xor_sweep_pkg::*;
#(
   parameter int W      = 2,
   parameter int SETTLE = 1,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             resp,
   output logic [W-1:0]     stim,
   output logic             inv,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic             fail_valid,
   output logic [W-1:0]     fail_stim,
   output logic             fail_inv
);

   // The settle counter must be able to hold SETTLE, and it needs at least one bit.
   localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   state_t           state;
   logic [CNT_W-1:0] settle_cnt;
   logic             mismatch;
   logic             clr_err;

   // An X or Z on resp must score as a failure, so the compare is a case-inequality.
   assign mismatch = (state == CHECK) && (resp !== exp_parity(32'(stim), inv));
   assign clr_err  = ((state == IDLE) || (state == DONE)) && start;

   sat_counter #(
      .WIDTH(ERR_W)
   ) u_err_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr_err),
      .inc  (mismatch),
      .count(err_cnt)
   );

   // Sweep sequencer: apply a vector, let it settle, sample resp, and advance.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         settle_cnt <= '0;
         stim       <= '0;
         inv        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail_valid <= 1'b0;
         fail_stim  <= '0;
         fail_inv   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= APPLY;
                  stim       <= '0;
                  inv        <= 1'b0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  fail_valid <= 1'b0;
                  fail_stim  <= '0;
                  fail_inv   <= 1'b0;
               end
            end
            APPLY: begin
               settle_cnt <= CNT_W'(SETTLE);
               state      <= (SETTLE == 0) ? CHECK : WAIT;
            end
            WAIT: begin
               settle_cnt <= settle_cnt - CNT_W'(1);
               if (settle_cnt == CNT_W'(1)) begin
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (mismatch && !fail_valid) begin
                  fail_valid <= 1'b1;
                  fail_stim  <= stim;
                  fail_inv   <= inv;
               end
               if (stim != '1) begin
                  stim  <= stim + W'(1);
                  state <= APPLY;
               end else if (!inv) begin
                  stim  <= '0;
                  inv   <= 1'b1;
                  state <= APPLY;
               end else begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  // The counter updates on this same edge, so fold in this last check.
                  pass  <= (err_cnt == '0) && !mismatch;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/xor_sweep_checker.md
Name: xor_sweep_checker

Overview:
- Self-checking stimulus/response stage wrapped around an XOR-with-invert cell (z = ^in ^ v).
- Drives every input vector, once with the cell's invert control low and once with it high, then samples the cell's response after a settle delay.
- Compares each sample against the expected parity and reports the result as pass/fail, an error count and the first failing vector.
- Sits directly upstream of the cell (feeds its inputs) and directly downstream of it (consumes its z).

Parameters:
- W, 2, width of the stimulus vector driven to the cell.
- SETTLE, 1, idle cycles between applying a vector and sampling resp (0 allowed).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse that begins a sweep; honoured only in IDLE or DONE.
- resp  input  1  cell output z.
- stim  output  W  vector driven to the cell's data inputs.
- inv  output  1  invert level applied to the cell; equals the expected v.
- busy  output  1  high from the cycle after start until DONE is entered.
- done  output  1  high while in DONE.
- pass  output  1  valid when done; 1 iff err_cnt == 0.
- err_cnt  output  ERR_W  mismatch count; saturates at 2^ERR_W-1.
- fail_valid  output  1  set on the first mismatch of a sweep.
- fail_stim  output  W  stim value at the first mismatch.
- fail_inv  output  1  inv value at the first mismatch.

Behaviour:
- Reset (rst_n=0 at a clk edge), whether idle or mid-sweep:
  - state=IDLE.
  - stim, inv, busy, done, pass, err_cnt, fail_valid, fail_stim, fail_inv all 0.
  - Settle counter 0.
- States: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE/DONE, start=1 -> APPLY:
  - stim=0, inv=0.
  - err_cnt, fail_* and pass cleared.
  - done=0, busy=1.
- APPLY: stim/inv are stable at the outputs. Load the settle counter with SETTLE. Next state is WAIT, or CHECK if SETTLE==0.
- WAIT: decrement the counter each cycle; go to CHECK in the cycle the counter reaches 1.
- CHECK (resp is sampled this edge):
  - exp = ^stim ^ inv.
  - Mismatch if resp !== exp; X/Z on resp counts as a mismatch.
  - On mismatch: err_cnt increments unless already saturated. If fail_valid==0, capture fail_stim=stim, fail_inv=inv, fail_valid=1.
  - Then:
    - stim != all-ones: stim+1 -> APPLY.
    - stim == all-ones and inv==0: stim=0, inv=1 -> APPLY. This is a wrap, not an overflow.
    - stim == all-ones and inv==1 -> DONE.
- DONE:
  - done=1, busy=0, pass=(err_cnt==0).
  - stim and inv hold their last values.
  - State persists until start or reset.
- Cycles per vector: 2+SETTLE. Sweep length: 2*2^W*(2+SETTLE) cycles from the first APPLY to DONE entry.
- start while busy is ignored and has no side effects.
- A mismatch arriving at the same edge the counter saturates leaves the count at the maximum; fail capture is unaffected.
- All outputs are registered; no combinational path from resp to any output.

Decomposition:
- Shared package xor_sweep_pkg contains:
  - state enum (IDLE, APPLY, WAIT, CHECK, DONE).
  - function exp_parity(vec, inv).
- One sub-module, sat_counter (parameter WIDTH; inputs clk, rst_n, clr, inc; output count). It is instantiated for err_cnt.

Test Plan:
- Correct cell, W=2, SETTLE=1 -> done rises exactly 24 cycles after the first APPLY; pass=1, err_cnt=0, fail_valid=0.
- resp stuck at 0 -> err_cnt=4 (vectors 01,10 with inv=0; 00,11 with inv=1); fail_stim=2'b01, fail_inv=0; pass=0.
- Cell whose v never follows inv (v held 0) -> err_cnt=4; fail_stim=2'b00, fail_inv=1.
- ERR_W=2 with resp = inverted expected -> 8 mismatches and err_cnt saturates at 3; fail_stim=2'b00, fail_inv=0.
- rst_n=0 for one cycle during the inv=1 pass -> next cycle: IDLE, all outputs 0. A later start runs a full sweep with pass=1.
- start pulsed mid-sweep -> no effect on stim sequence or counts; start in DONE -> counters cleared and a new sweep begins at stim=0, inv=0.
